// File: rtl/pipe_sched_pkg.sv
// pipe_sched_pkg: scheduler FSM states and the in-flight tag record.
package pipe_sched_pkg;
    localparam int NUM_REQ_DEF = 4;
    localparam int ID_W = $clog2(NUM_REQ_DEF);
    typedef enum logic [1:0] {ISSUE, HOLD, DRAIN, DRAINED} state_t;
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/pipe_issue_scheduler_if.sv
// pipe_issue_scheduler_if: bundles the scheduler's requester, datapath and drain signals.
//  req_valid/req_data/req_ready       requester operands and one-hot grant
//  pipe_valid/pipe_data               issue into the datapath
//  pipe_res_valid/pipe_res_data       datapath results; pipe_flush clears its stages
//  resp_valid/resp_id/resp_data       routed result; drop_mask reports flushed owners
//  drain_req/drain_done/err_mismatch  quiesce control and sticky tag error
interface pipe_issue_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          pipe_valid;
    logic [DATA_WIDTH-1:0]         pipe_data;
    logic                          pipe_res_valid;
    logic [DATA_WIDTH-1:0]         pipe_res_data;
    logic                          pipe_flush;
    logic                          resp_valid;
    logic [$clog2(NUM_REQ)-1:0]    resp_id;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic [NUM_REQ-1:0]            drop_mask;
    logic                          drain_req;
    logic                          drain_done;
    logic                          err_mismatch;
    modport slave (
        input  req_valid, req_data, pipe_res_valid, pipe_res_data, pipe_flush, drain_req,
        output req_ready, pipe_valid, pipe_data, resp_valid, resp_id, resp_data,
               drop_mask, drain_done, err_mismatch
    );
    modport master (
        output req_valid, req_data, pipe_res_valid, pipe_res_data, pipe_flush, drain_req,
        input  req_ready, pipe_valid, pipe_data, resp_valid, resp_id, resp_data,
               drop_mask, drain_done, err_mismatch
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, combinational one-hot grant, pointer moves to each winner.
//  clk, rst   clock, asynchronous active-high reset (pointer resets so requester 0 wins first)
//  req, en    request vector and grant enable
//  gnt        one-hot grant; gnt_id/gnt_valid give the winner index and whether anyone won
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       gnt_valid
);
    localparam int IW = $clog2(NUM_REQ);
    logic [IW-1:0] ptr, idx;
    always_comb begin
        gnt_id = '0;
        gnt_valid = 1'b0;
        idx = '0;
        // scan farthest-first so the nearest requester after ptr overwrites earlier hits
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % NUM_REQ);
            if (en && req[idx]) begin
                gnt_id = idx;
                gnt_valid = 1'b1;
            end
        end
        gnt = gnt_valid ? NUM_REQ'(1) << gnt_id : '0;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= IW'(NUM_REQ - 1);
        else if (gnt_valid) ptr <= gnt_id;
endmodule

// File: rtl/pipe_issue_scheduler.sv
// pipe_issue_scheduler: shares one fixed-latency datapath among requesters with tag tracking.
//  clk, rst   clock, asynchronous active-high reset
//  bus        requester grant/operands, datapath issue/results/flush, routed responses,
//             flush drop pulse, drain handshake and sticky mismatch flag
module pipe_issue_scheduler
    import pipe_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int LATENCY    = 4,
    parameter int FLUSH_HOLD = 2
) (
    input logic                    clk,
    input logic                    rst,
    pipe_issue_scheduler_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(FLUSH_HOLD + 1);
    state_t            state, state_n;
    logic [HW-1:0]     hold_cnt;
    tag_t              slot [LATENCY];
    logic [NUM_REQ-1:0] gnt, drop_n;
    logic [IW-1:0]     gnt_id;
    logic              gnt_valid, busy;
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .en        (state == ISSUE && !bus.pipe_flush),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );
    assign bus.req_ready  = gnt;
    assign bus.drain_done = state == DRAINED;
    always_comb begin
        busy = 1'b0;
        drop_n = '0;
        for (int i = 0; i < LATENCY; i++) busy |= slot[i].valid;
        // current slots 0..LATENCY-3 shift into the cleared region; the one entering the
        // output-register slot survives the flush
        for (int i = 0; i < LATENCY - 2; i++)
            if (bus.pipe_flush && slot[i].valid) drop_n[slot[i].id] = 1'b1;
    end
    always_comb begin
        state_n = state;
        case (state)
            ISSUE:   state_n = bus.pipe_flush ? HOLD : bus.drain_req ? DRAIN : ISSUE;
            // a further flush while holding restarts the hold window
            HOLD:    state_n = (!bus.pipe_flush && hold_cnt == HW'(FLUSH_HOLD - 1)) ? ISSUE : HOLD;
            DRAIN:   state_n = busy ? DRAIN : DRAINED;
            DRAINED: state_n = bus.drain_req ? DRAINED : ISSUE;
            default: state_n = ISSUE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ISSUE;
            hold_cnt         <= '0;
            bus.pipe_valid   <= 1'b0;
            bus.pipe_data    <= '0;
            bus.resp_valid   <= 1'b0;
            bus.resp_id      <= '0;
            bus.resp_data    <= '0;
            bus.drop_mask    <= '0;
            bus.err_mismatch <= 1'b0;
            for (int i = 0; i < LATENCY; i++) slot[i] <= '0;
        end else begin
            state            <= state_n;
            hold_cnt         <= (state == HOLD && !bus.pipe_flush) ? hold_cnt + 1'b1 : '0;
            bus.pipe_valid   <= gnt_valid;
            if (gnt_valid) bus.pipe_data <= bus.req_data[gnt_id*DATA_WIDTH +: DATA_WIDTH];
            slot[0]          <= gnt_valid ? {1'b1, ID_W'(gnt_id)} : '0;
            for (int i = 1; i < LATENCY; i++)
                slot[i] <= (bus.pipe_flush && i < LATENCY - 1) ? '0 : slot[i-1];
            bus.resp_valid   <= bus.pipe_res_valid && slot[LATENCY-1].valid;
            bus.resp_id      <= slot[LATENCY-1].id;
            bus.resp_data    <= bus.pipe_res_data;
            bus.drop_mask    <= drop_n;
            bus.err_mismatch <= bus.err_mismatch | (bus.pipe_res_valid ^ slot[LATENCY-1].valid);
        end
    end
endmodule

// File: tb/tb_pipe_issue_scheduler.sv
// tb_pipe_issue_scheduler: random and directed stimulus against a transaction-level model.
module tb_pipe_issue_scheduler;
    localparam int DW = 8, N = 4, L = 4, FH = 2, IW = 2;
    localparam int M_ISSUE = 0, M_HOLD = 1, M_DRAIN = 2, M_DRAINED = 3;
    typedef struct {int owner; int res_cyc; logic [DW-1:0] data;} op_t;
    typedef struct {int id; logic [DW-1:0] data;} rsp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    pipe_issue_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus ();
    pipe_issue_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(N), .LATENCY(L), .FLUSH_HOLD(FH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    op_t  fly[$];
    rsp_t exp_q[$];
    rsp_t r;
    int mode = M_ISSUE, rr = N - 1, hold_left = 0, cyc = 0;
    int checks = 0, passed = 0;
    logic exp_pv = 1'b0, exp_err = 1'b0, exp_done = 1'b0, exp_rv = 1'b0;
    logic [DW-1:0] exp_pd = '0;
    logic [N-1:0]  exp_drop = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // one datapath cycle: drive inputs, predict, then advance to the next negedge
    task automatic step(input logic [N-1:0] rv, input logic fl, input logic dr,
                        input logic orphan, input logic [N*DW-1:0] d);
        int w;
        logic hit, busy;
        logic [N-1:0] dm, rdy;
        w = -1; hit = 1'b0; busy = 1'b0; dm = '0;
        foreach (fly[i]) if (fly[i].owner >= 0 && fly[i].res_cyc >= cyc) busy = 1'b1;
        bus.req_valid = rv;
        bus.req_data = d;
        bus.pipe_flush = fl;
        bus.drain_req = dr;
        bus.pipe_res_valid = orphan;
        bus.pipe_res_data = DW'($urandom);
        foreach (fly[i]) if (fly[i].res_cyc == cyc) begin
            bus.pipe_res_valid = 1'b1;
            bus.pipe_res_data = fly[i].data ^ 8'h5A;
            hit = fly[i].owner >= 0;
        end
        exp_err = exp_err | (bus.pipe_res_valid ^ hit);
        exp_rv = hit;
        if (mode == M_ISSUE && !fl)
            for (int k = 1; k <= N; k++)
                if (w < 0 && rv[IW'((rr + k) % N)]) w = (rr + k) % N;
        rdy = (w >= 0) ? N'(1) << w : '0;
        #1 chk("req_ready", bus.req_ready, rdy);
        if (fl)
            for (int i = fly.size() - 1; i >= 0; i--)
                if (fly[i].res_cyc >= cyc + 2) begin
                    if (fly[i].owner >= 0) begin
                        dm[IW'(fly[i].owner)] = 1'b1;
                        void'(exp_q.pop_back());
                    end
                    fly.delete(i);
                end
        exp_drop = dm;
        exp_pv = w >= 0;
        if (w >= 0) begin
            rr = w;
            exp_pd = d[w*DW +: DW];
            fly.push_back('{owner: w, res_cyc: cyc + L, data: exp_pd});
            exp_q.push_back('{id: w, data: exp_pd ^ 8'h5A});
        end
        case (mode)
            M_ISSUE: if (fl) begin mode = M_HOLD; hold_left = FH; end
                     else if (dr) mode = M_DRAIN;
            M_HOLD: begin hold_left--; if (hold_left == 0) mode = M_ISSUE; end
            M_DRAIN: if (!busy) mode = M_DRAINED;
            default: if (!dr) mode = M_ISSUE;
        endcase
        exp_done = mode == M_DRAINED;
        for (int i = fly.size() - 1; i >= 0; i--) if (fly[i].res_cyc <= cyc) fly.delete(i);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, 1'b0, 32'($urandom));
    endtask

    // asynchronous reset for two cycles; ops already in the datapath become untracked
    task automatic do_reset();
        bus.req_valid = '0;
        bus.pipe_flush = 1'b0;
        bus.drain_req = 1'b0;
        bus.pipe_res_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_pipe_valid", bus.pipe_valid, 1'b0);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_err", bus.err_mismatch, 1'b0);
        chk("rst_drop", bus.drop_mask, '0);
        chk("rst_drain_done", bus.drain_done, 1'b0);
        chk("rst_req_ready", bus.req_ready, '0);
        mode = M_ISSUE; rr = N - 1; hold_left = 0;
        exp_q.delete();
        foreach (fly[i]) fly[i].owner = -1;
        exp_pv = 1'b0; exp_err = 1'b0; exp_done = 1'b0; exp_rv = 1'b0; exp_drop = '0;
        for (int k = 0; k < 2; k++) begin
            for (int i = fly.size() - 1; i >= 0; i--) if (fly[i].res_cyc <= cyc) fly.delete(i);
            cyc++;
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        chk("pipe_valid", bus.pipe_valid, exp_pv);
        if (exp_pv) chk("pipe_data", bus.pipe_data, exp_pd);
        chk("drop_mask", bus.drop_mask, exp_drop);
        chk("drain_done", bus.drain_done, exp_done);
        chk("err_mismatch", bus.err_mismatch, exp_err);
        chk("resp_valid", bus.resp_valid, exp_rv);
        if (bus.resp_valid && exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("resp_id", bus.resp_id, r.id);
            chk("resp_data", bus.resp_data, r.data);
        end
    end

    initial begin
        logic dr, fl;
        bus.req_valid = '0; bus.req_data = '0; bus.pipe_flush = 1'b0; bus.drain_req = 1'b0;
        bus.pipe_res_valid = 1'b0; bus.pipe_res_data = '0;
        @(negedge clk);
        do_reset();
        step(4'b0001, 1'b0, 1'b0, 1'b0, 32'h0000_0012);
        idle(6);
        do_reset();
        for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 1'b0, 1'b0, 32'($urandom));
        idle(6);
        do_reset();
        step(4'b0010, 1'b0, 1'b0, 1'b0, 32'($urandom));
        step(4'b0100, 1'b0, 1'b0, 1'b0, 32'($urandom));
        step(4'b1000, 1'b0, 1'b0, 1'b0, 32'($urandom));
        step(4'b0000, 1'b0, 1'b0, 1'b0, 32'($urandom));
        step(4'b1111, 1'b1, 1'b0, 1'b0, 32'($urandom));
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0, 1'b0, 32'($urandom));
        idle(6);
        step(4'b0000, 1'b1, 1'b0, 1'b0, 32'($urandom));
        idle(4);
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, i == 2, 1'b0, 32'($urandom));
        for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 1'b1, 1'b0, 32'($urandom));
        idle(6);
        dr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) dr = !dr;
            fl = mode != M_HOLD && $urandom_range(0, 11) == 0;
            step(N'($urandom), fl, dr, 1'b0, 32'($urandom));
        end
        idle(10);
        chk("queue_empty", exp_q.size(), 0);
        step(4'b0000, 1'b0, 1'b0, 1'b1, 32'($urandom));
        idle(4);
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0, 1'b0, 32'($urandom));
        do_reset();
        idle(8);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
